bus_fabric: RTL and testbench
=============================

BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_SLAVES, 4, number of slave regions, 1..16.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- REGION_BITS, 16, low address bits forwarded to slaves; the upper bits form the region index.
- TIMEOUT, 255, maximum ACCESS cycles before an error response, 1..255.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- n_reset, in, 1, asynchronous active-low reset.
- m_req, in, 1, master request; sampled in IDLE only.
- m_we, in, 1, 1 = write, 0 = read.
- m_addr, in, ADDR_W, master address.
- m_wdata, in, DATA_W, write data.
- m_ready, out, 1, one-cycle completion pulse.
- m_rdata, out, DATA_W, read data, valid while m_ready=1.
- m_err, out, 1, error flag, valid while m_ready=1.
- s_sel, out, NUM_SLAVES, one-hot slave select.
- s_we, out, 1, latched write enable.
- s_addr, out, REGION_BITS, latched m_addr[REGION_BITS-1:0].
- s_wdata, out, DATA_W, latched write data.
- s_rdata, in, NUM_SLAVES*DATA_W, slave read data; slave i occupies slice [i*DATA_W +: DATA_W].
- s_ready, in, NUM_SLAVES, per-slave completion; a slave may hold it low to insert wait states.
- err_count, out, 8, saturating count of error responses.

Function
REQ-003 Region index SHALL be m_addr[ADDR_W-1:REGION_BITS]; index >= NUM_SLAVES SHALL be a decode error.
REQ-004 FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-005 In IDLE with m_req=1, the block SHALL latch m_we, m_addr and m_wdata, then go to ACCESS if the index is valid, or to RESP with error set if it is not.
REQ-006 In ACCESS, s_sel SHALL have exactly bit[index] set, and s_we, s_addr and s_wdata SHALL hold their latched values; master input changes SHALL be ignored.
REQ-007 In ACCESS, s_ready[index]=1 SHALL register s_rdata slice[index] for reads (zero for writes), clear error, and go to RESP; s_ready of unselected slaves SHALL be ignored.
REQ-008 In ACCESS, the timeout counter SHALL increment each cycle and clear on ACCESS entry; a count of TIMEOUT-1 without s_ready SHALL end the access with error set and go to RESP. If s_ready and timeout occur in the same cycle, s_ready SHALL win.
REQ-009 In RESP, the block SHALL drive m_ready=1 for exactly one cycle and return to IDLE; s_sel SHALL be 0; m_req in RESP SHALL be ignored.
REQ-010 With error set, m_rdata SHALL be 0 and m_err SHALL be 1.
REQ-011 m_ready, m_err and m_rdata SHALL be 0 outside RESP.
REQ-012 Minimum latency for a valid region SHALL be: request accepted in cycle 0, ACCESS in cycle 1 with s_ready=1, m_ready in cycle 2. A decode error SHALL raise m_ready in cycle 1.
REQ-013 err_count SHALL increment by one per error response (decode or timeout) and saturate at 255.
REQ-014 Back-to-back accesses: a request held through RESP SHALL be accepted in the IDLE cycle that follows.

Reset
REQ-015 When n_reset=0, asynchronously: state=IDLE; s_sel, m_ready, m_err, s_we = 0; m_rdata, s_addr, s_wdata = 0; timeout counter = 0; err_count = 0.
REQ-016 Reset asserted mid-access SHALL abort the access without producing an m_ready pulse.

Structure
REQ-017 A shared package bus_pkg SHALL hold the state enum (IDLE/ACCESS/RESP) and the default DATA_W, ADDR_W and REGION_BITS constants.
REQ-018 Region decoding SHALL be a sub-module bus_region_decode (address in -> index, valid out, purely combinational); all state SHALL stay in bus_fabric.

Verification
REQ-019 Read at 0x0001_0010 with slave 1 returning 0xDEADBEEF and s_ready in the first ACCESS cycle -> s_sel=0b0010, s_addr=0x0010, m_ready in cycle 2, m_rdata=0xDEADBEEF, m_err=0.
REQ-020 Write 0x12345678 to 0x0002_0004 with slave 2 holding s_ready low 5 cycles -> s_wdata, s_addr and s_sel stable for 6 ACCESS cycles, then m_ready with m_rdata=0 and m_err=0.
REQ-021 Read at 0x0007_0000 with NUM_SLAVES=4 -> no s_sel asserted, m_ready in cycle 1, m_err=1, m_rdata=0, err_count=1.
REQ-022 TIMEOUT=8, slave 0 never ready -> s_sel=0b0001 for 8 cycles, then m_err=1; 300 such timeouts -> err_count=255.
REQ-023 n_reset pulsed low in the 3rd ACCESS cycle -> all outputs 0 immediately, no m_ready pulse, next request served normally.
REQ-024 m_req held high across two reads to slaves 0 and 3 -> two m_ready pulses separated by one IDLE cycle, each carrying the correct slice.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus fabric: FSM state encoding and default widths.
package bus_pkg;

  localparam int BUS_ADDR_W      = 32;
  localparam int BUS_DATA_W      = 32;
  localparam int BUS_REGION_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } bus_state_e;

  // Saturating 8-bit increment used by the error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/bus_region_decode.sv
// Splits a master address into a slave index, a validity flag and the in-region offset.
// Purely combinational; the fabric owns all state.
module bus_region_decode
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int REGION_BITS = BUS_REGION_BITS,
  parameter int IDX_W       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic [IDX_W-1:0]       index,
  output logic                   valid,
  output logic [REGION_BITS-1:0] offset
);

  logic [ADDR_W-REGION_BITS-1:0] region;

  assign region = addr[ADDR_W-1:REGION_BITS];
  assign offset = addr[REGION_BITS-1:0];
  assign index  = IDX_W'(region);
  // The full region field is compared so high aliases of a valid index are rejected.
  assign valid  = (32'(region) < NUM_SLAVES);

endmodule

// File: rtl/bus_fabric.sv
// Single-master to multi-slave fabric: address decode, wait-state tolerant access,
// timeout with error response, and a saturating error counter.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int REGION_BITS = BUS_REGION_BITS,
  parameter int TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         m_req,
  input  logic                         m_we,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic                         m_ready,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic                         s_we,
  output logic [REGION_BITS-1:0]       s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  output logic [7:0]                   err_count
);

  localparam int         IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  bus_state_e             state;
  bus_state_e             next_state;
  logic [IDX_W-1:0]       dec_index;
  logic                   dec_valid;
  logic [REGION_BITS-1:0] dec_offset;
  logic [IDX_W-1:0]       idx_q;
  logic                   err_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [7:0]             to_cnt;
  logic                   slave_ready;
  logic                   timed_out;
  logic                   accept;
  logic                   finish_err;

  bus_region_decode #(
    .NUM_SLAVES  (NUM_SLAVES),
    .ADDR_W      (ADDR_W),
    .REGION_BITS (REGION_BITS),
    .IDX_W       (IDX_W)
  ) u_decode (
    .addr   (m_addr),
    .index  (dec_index),
    .valid  (dec_valid),
    .offset (dec_offset)
  );

  assign slave_ready = s_ready[idx_q];
  assign timed_out   = (to_cnt == TO_LAST);

  // Master-facing outputs are only live during the single RESP cycle.
  assign m_ready = (state == RESP);
  assign m_err   = (state == RESP) && err_q;
  assign m_rdata = ((state == RESP) && !err_q) ? rdata_q : '0;
  assign s_sel   = (state == ACCESS) ? (NUM_SLAVES'(1) << idx_q) : '0;

  // State register; reset drops straight to IDLE so an in-flight access never completes.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a slave completion takes priority over a same-cycle timeout.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    finish_err = 1'b0;
    case (state)
      IDLE: begin
        if (m_req) begin
          accept     = 1'b1;
          next_state = dec_valid ? ACCESS : RESP;
          finish_err = !dec_valid;
        end
      end
      ACCESS: begin
        if (slave_ready) begin
          next_state = RESP;
        end else if (timed_out) begin
          next_state = RESP;
          finish_err = 1'b1;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latching, response capture, timeout counting and error accounting.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      to_cnt    <= '0;
      err_count <= '0;
    end else begin
      if (accept) begin
        s_we    <= m_we;
        s_addr  <= dec_offset;
        s_wdata <= m_wdata;
        err_q   <= !dec_valid;
        rdata_q <= '0;
        to_cnt  <= '0;
        if (dec_valid) begin
          idx_q <= dec_index;
        end
      end
      if (state == ACCESS) begin
        if (slave_ready) begin
          rdata_q <= s_we ? '0 : s_rdata[idx_q*DATA_W +: DATA_W];
          err_q   <= 1'b0;
        end else if (timed_out) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 8'd1;
        end
      end
      if (finish_err) begin
        err_count <= sat_inc8(err_count);
      end
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: expected responses are queued when a request is
// driven and compared when m_ready pulses; a simple slave model inserts wait states.
module tb_bus_fabric;

  localparam int NS = 4;
  localparam int TO = 8;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          m_req = 1'b0;
  logic          m_we = 1'b0;
  logic [31:0]   m_addr = '0;
  logic [31:0]   m_wdata = '0;
  logic          m_ready;
  logic [31:0]   m_rdata;
  logic          m_err;
  logic [NS-1:0] s_sel;
  logic          s_we;
  logic [15:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [NS*32-1:0] s_rdata;
  logic [NS-1:0] s_ready = '1;
  logic [7:0]    err_count;

  logic [31:0] slave_data [NS] = '{32'h1111_0000, 32'hDEADBEEF, 32'h2222_2222, 32'h3333_CAFE};
  int          wait_states [NS] = '{0, 0, 0, 0};
  resp_t       sb [$];
  int          assert_count = 0;
  int          fail_count = 0;
  int          exp_err_count = 0;

  bus_fabric #(
    .NUM_SLAVES (NS),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .m_err     (m_err),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Pack per-slave read data onto the flat bus.
  always_comb begin
    s_rdata = '0;
    for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = slave_data[i];
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Slave model: the selected slave raises s_ready after its wait count; unselected
  // slaves always drive ready so the fabric must ignore them.
  initial begin
    int acc_n;
    int idx;
    acc_n = 0;
    forever begin
      @(negedge clk);
      if (s_sel == '0) begin
        acc_n   = 0;
        s_ready = '1;
      end else begin
        idx = 0;
        for (int i = 0; i < NS; i++) if (s_sel[i]) idx = i;
        s_ready = ~s_sel;
        if (acc_n >= wait_states[idx]) s_ready[idx] = 1'b1;
        acc_n++;
      end
    end
  end

  // Response monitor: pops the scoreboard on every m_ready, checks quiet outputs otherwise.
  initial begin
    resp_t exp;
    forever begin
      @(negedge clk);
      if (m_ready) begin
        if (sb.size() == 0) begin
          check_output("unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp = sb.pop_front();
          check_output("m_rdata", m_rdata, exp.rdata);
          check_output("m_err", {31'd0, m_err}, {31'd0, exp.err});
        end
      end else begin
        check_output("quiet_outputs", {31'd0, m_err} | m_rdata, 32'd0);
      end
    end
  end

  // One complete transaction with expected timing derived from the slave wait count.
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int         region;
    int         exp_acc;
    int         cycles;
    int         acc_seen;
    int         bad;
    logic       dec_err;
    logic       to_err;
    logic [3:0] exp_sel;
    resp_t      exp;
    region  = int'(addr[31:16]);
    dec_err = (region >= NS);
    to_err  = 1'b0;
    exp_acc = 0;
    exp_sel = 4'b0;
    if (!dec_err) begin
      to_err  = (wait_states[region] >= TO);
      exp_acc = to_err ? TO : wait_states[region] + 1;
      exp_sel = 4'(1 << region);
    end
    exp.err   = dec_err || to_err;
    exp.rdata = (exp.err || we) ? 32'h0 : slave_data[region];
    if (exp.err && exp_err_count < 255) exp_err_count++;

    @(negedge clk);
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
    sb.push_back(exp);
    @(negedge clk);
    m_req = 1'b0; m_we = ~we; m_addr = ~addr; m_wdata = ~wdata;
    cycles = 1; acc_seen = 0; bad = 0;
    while (!m_ready && cycles < 40) begin
      acc_seen++;
      if (s_sel !== exp_sel || s_addr !== addr[15:0] || s_wdata !== wdata || s_we !== we) bad++;
      @(negedge clk);
      cycles++;
    end
    check_output("latency", cycles, exp_acc + 1);
    check_output("access_cycles", acc_seen, exp_acc);
    check_output("access_bad", bad, 0);
    check_output("sel_in_resp", {28'd0, s_sel}, 32'd0);
    check_output("err_count", {24'd0, err_count}, exp_err_count);
  endtask

  initial begin
    int first_rdy;
    int second_rdy;
    int rdy_seen;
    resp_t r;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_m_ready", {31'd0, m_ready}, 32'd0);
    check_output("rst_s_sel", {28'd0, s_sel}, 32'd0);
    check_output("rst_s_addr", {16'd0, s_addr}, 32'd0);
    check_output("rst_err_count", {24'd0, err_count}, 32'd0);
    n_reset = 1'b1;

    // Minimum latency read, slave 1.
    apply_stimulus(1'b0, 32'h0001_0010, 32'h0);
    // Write to slave 2 with 5 wait states.
    wait_states[2] = 5;
    apply_stimulus(1'b1, 32'h0002_0004, 32'h1234_5678);
    // Decode error.
    apply_stimulus(1'b0, 32'h0007_0000, 32'h0);
    // Ready on the last allowed cycle wins; one more wait state times out.
    wait_states[3] = TO - 1;
    apply_stimulus(1'b0, 32'h0003_0008, 32'h0);
    wait_states[3] = TO;
    apply_stimulus(1'b0, 32'h0003_000C, 32'h0);

    // Back-to-back reads, request held high through RESP.
    wait_states[3] = 0;
    r.err = 1'b0;
    r.rdata = slave_data[0]; sb.push_back(r);
    r.rdata = slave_data[3]; sb.push_back(r);
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0100;
    first_rdy = -1; second_rdy = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) m_addr = 32'h0003_0200;
      if (c == 4) m_req = 1'b0;
      if (m_ready) begin
        if (first_rdy < 0) first_rdy = c;
        else second_rdy = c;
      end
    end
    check_output("b2b_first", first_rdy, 2);
    check_output("b2b_second", second_rdy, 5);

    // Reset in the third ACCESS cycle aborts the write.
    wait_states[1] = 20;
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0001_0020; m_wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    m_req = 1'b0;
    repeat (2) @(negedge clk);
    check_output("pre_reset_sel", {28'd0, s_sel}, 32'h2);
    n_reset = 1'b0;
    #1;
    check_output("arst_s_sel", {28'd0, s_sel}, 32'd0);
    check_output("arst_m_ready", {31'd0, m_ready}, 32'd0);
    check_output("arst_s_we", {31'd0, s_we}, 32'd0);
    check_output("arst_s_addr", {16'd0, s_addr}, 32'd0);
    check_output("arst_s_wdata", s_wdata, 32'd0);
    check_output("arst_err_count", {24'd0, err_count}, 32'd0);
    exp_err_count = 0;
    #2 n_reset = 1'b1;
    rdy_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (m_ready) rdy_seen++;
    end
    check_output("no_ready_after_abort", rdy_seen, 0);
    wait_states[1] = 0;
    apply_stimulus(1'b0, 32'h0001_0040, 32'h0);
    wait_states[0] = 2;
    apply_stimulus(1'b1, 32'h0000_FFFC, 32'hCAFE_F00D);

    // Repeated timeouts drive the error counter into saturation.
    wait_states[0] = 1000;
    for (int n = 0; n < 300; n++) begin
      apply_stimulus(1'b0, {16'h0000, 16'($urandom_range(0, 16'hFFFF))}, 32'h0);
      if (n == 100) check_output("err_count_mid", {24'd0, err_count}, 32'd101);
    end
    check_output("err_count_sat", {24'd0, err_count}, 32'd255);

    repeat (3) @(negedge clk);
    check_output("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
